dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dm_arbiter
//  Purpose  : Two-port data-memory arbiter with port-1 locked bursts, lane
//             code generation, misalignment detection and load responses.
//  Revision : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_0,
  input  logic        we_0,
  input  logic [31:0] addr_0,
  input  logic [1:0]  size_0,
  input  logic [31:0] wdata_0,
  output logic        gnt_0,
  output logic        rvalid_0,
  output logic [31:0] rdata_0,
  output logic        err_0,
  input  logic        req_1,
  input  logic        we_1,
  input  logic [31:0] addr_1,
  input  logic [1:0]  size_1,
  input  logic [31:0] wdata_1,
  output logic        gnt_1,
  output logic        rvalid_1,
  output logic [31:0] rdata_1,
  output logic        err_1,
  input  logic        lock1,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int              CW      = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(LOCK_MAX);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } state_t;

  state_t        state;
  logic          last;     // 1: port 1 was served last, so port 0 wins a tie
  logic [CW-1:0] cnt;      // port-1 transfers in the current locked run

  logic          lock_expire;
  logic          xfer;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [1:0]    sel_size;
  logic [31:0]   sel_wdata;
  logic [3:0]    lane;
  logic          lane_ok;

  // Lane code for a transfer; zero marks a misaligned or illegal-size access.
  function automatic logic [3:0] lane_code(input logic [1:0] size, input logic [1:0] b);
    logic [3:0] code;
    code = 4'b0000;
    case (size)
      2'b00:   code = 4'b0001 << b;
      2'b01:   code = (b == 2'b00) ? 4'b0011 : ((b == 2'b10) ? 4'b1100 : 4'b0000);
      2'b10:   code = (b == 2'b00) ? 4'b1111 : 4'b0000;
      default: code = 4'b0000;
    endcase
    return code;
  endfunction

  // The lock budget is spent and port 0 is waiting: port 1 must yield now,
  // so no port-1 grant is issued in the cycle the burst is broken.
  assign lock_expire = (cnt == CNT_MAX) && req_0;

  // Grant selection: round-robin tie break in ARB, port 1 only while locked.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (!reset) begin
      if (state == ARB) begin
        if (req_0 && req_1) begin
          gnt_0 = last;
          gnt_1 = !last;
        end else begin
          gnt_0 = req_0;
          gnt_1 = req_1;
        end
      end else begin
        gnt_1 = req_1 && !lock_expire;
      end
    end
  end

  // Steer the granted port onto the memory bus; idle bus is driven to zero.
  always_comb begin
    xfer      = gnt_0 | gnt_1;
    sel_we    = gnt_1 ? we_1    : we_0;
    sel_addr  = gnt_1 ? addr_1  : addr_0;
    sel_size  = gnt_1 ? size_1  : size_0;
    sel_wdata = gnt_1 ? wdata_1 : wdata_0;
    lane      = lane_code(sel_size, sel_addr[1:0]);
    lane_ok   = (lane != 4'b0000);
    mem_addr  = xfer ? sel_addr  : 32'h0;
    mem_be    = xfer ? lane      : 4'b0000;
    mem_wdata = xfer ? sel_wdata : 32'h0;
    mem_we    = xfer & sel_we & lane_ok;
  end

  // Arbitration state machine: ARB/LOCK1, last-served bit and lock run count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      if (xfer) last <= gnt_1;
      case (state)
        ARB: begin
          if (gnt_1 && lock1) begin
            state <= LOCK1;
            cnt   <= CW'(1);
          end
        end
        LOCK1: begin
          if (!lock1) begin
            state <= ARB;
            cnt   <= '0;
          end else if (lock_expire) begin
            state <= ARB;
            cnt   <= '0;
            last  <= 1'b1;
          end else if (gnt_1 && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ARB;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Per-port responses: load data/valid pulse or error pulse one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      err_0    <= 1'b0;
      err_1    <= 1'b0;
      rdata_0  <= 32'h0;
      rdata_1  <= 32'h0;
    end else begin
      rvalid_0 <= gnt_0 & !we_0 & lane_ok;
      rvalid_1 <= gnt_1 & !we_1 & lane_ok;
      err_0    <= gnt_0 & !lane_ok;
      err_1    <= gnt_1 & !lane_ok;
      if (gnt_0 && !we_0 && lane_ok) rdata_0 <= mem_rdata;
      if (gnt_1 && !we_1 && lane_ok) rdata_1 <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_arbiter
//  Purpose  : Self-checking bench for dm_arbiter: behavioural model compared
//             every cycle, plus directed vectors with literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

  localparam int LOCK_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_0, we_0, req_1, we_1, lock1;
  logic [31:0] addr_0, wdata_0, addr_1, wdata_1, mem_rdata;
  logic [1:0]  size_0, size_1;
  logic        gnt_0, rvalid_0, err_0, gnt_1, rvalid_1, err_1, mem_we;
  logic [31:0] rdata_0, rdata_1, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  dm_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .size_0(size_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0), .err_0(err_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .size_1(size_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1), .err_1(err_1),
    .lock1(lock1),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_lock = 0;     // 1 while a port-1 burst owns the memory
  int          m_cnt  = 0;     // port-1 transfers in the current burst
  int          m_last = 1;     // port served most recently
  logic        armed  = 1'b0;
  logic        e_rv0 = 0, e_rv1 = 0, e_er0 = 0, e_er1 = 0;
  logic [31:0] e_rd0 = 0, e_rd1 = 0;

  // Byte lanes: a transfer of n bytes is legal only at an offset divisible by n.
  function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [31:0] a);
    int n, off;
    if (sz == 2'b11) return 4'b0000;
    n   = 1 << sz;
    off = int'(a[1:0]);
    if ((off % n) != 0) return 4'b0000;
    return 4'(((1 << n) - 1) << off);
  endfunction

  // Which port the rules award this cycle (-1 = none).
  function automatic int exp_grant();
    if (reset) return -1;
    if (m_lock == 0) begin
      if (req_0 && req_1) return (m_last == 1) ? 0 : 1;
      if (req_0) return 0;
      if (req_1) return 1;
      return -1;
    end
    if (m_cnt >= LOCK_MAX && req_0) return -1;
    return req_1 ? 1 : -1;
  endfunction

  // Advance the model at each clock edge.
  always @(posedge clk) begin
    armed <= 1'b1;
    if (reset) begin
      m_lock <= 0; m_cnt <= 0; m_last <= 1;
      e_rv0 <= 0; e_rv1 <= 0; e_er0 <= 0; e_er1 <= 0; e_rd0 <= 0; e_rd1 <= 0;
    end else begin
      e_rv0 <= (exp_grant() == 0) && !we_0 && (lanes(size_0, addr_0) != 0);
      e_rv1 <= (exp_grant() == 1) && !we_1 && (lanes(size_1, addr_1) != 0);
      e_er0 <= (exp_grant() == 0) && (lanes(size_0, addr_0) == 0);
      e_er1 <= (exp_grant() == 1) && (lanes(size_1, addr_1) == 0);
      if (exp_grant() == 0 && !we_0 && lanes(size_0, addr_0) != 0) e_rd0 <= mem_rdata;
      if (exp_grant() == 1 && !we_1 && lanes(size_1, addr_1) != 0) e_rd1 <= mem_rdata;
      if (exp_grant() >= 0) m_last <= exp_grant();
      if (m_lock == 0) begin
        if (exp_grant() == 1 && lock1) begin m_lock <= 1; m_cnt <= 1; end
      end else if (!lock1) begin
        m_lock <= 0; m_cnt <= 0;
      end else if (m_cnt >= LOCK_MAX && req_0) begin
        m_lock <= 0; m_cnt <= 0; m_last <= 1;
      end else if (exp_grant() == 1 && m_cnt < LOCK_MAX) begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      chk("gnt_0", 32'(gnt_0), 32'(exp_grant() == 0));
      chk("gnt_1", 32'(gnt_1), 32'(exp_grant() == 1));
      if (exp_grant() == 1) begin
        chk("mem_addr", mem_addr, addr_1);
        chk("mem_be", 32'(mem_be), 32'(lanes(size_1, addr_1)));
        chk("mem_we", 32'(mem_we), 32'(we_1 && lanes(size_1, addr_1) != 0));
        chk("mem_wdata", mem_wdata, wdata_1);
      end else if (exp_grant() == 0) begin
        chk("mem_addr", mem_addr, addr_0);
        chk("mem_be", 32'(mem_be), 32'(lanes(size_0, addr_0)));
        chk("mem_we", 32'(mem_we), 32'(we_0 && lanes(size_0, addr_0) != 0));
        chk("mem_wdata", mem_wdata, wdata_0);
      end else begin
        chk("mem_idle", {mem_addr[31:5], mem_be, mem_we} | mem_wdata | {27'h0, mem_addr[4:0]}, 32'h0);
      end
      chk("rvalid_0", 32'(rvalid_0), 32'(e_rv0));
      chk("rvalid_1", 32'(rvalid_1), 32'(e_rv1));
      chk("err_0", 32'(err_0), 32'(e_er0));
      chk("err_1", 32'(err_1), 32'(e_er1));
      chk("rdata_0", rdata_0, e_rd0);
      chk("rdata_1", rdata_1, e_rd1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [1:0] sz; logic [1:0] off; logic [3:0] be; } lane_vec_t;
  lane_vec_t lane_tbl [11] = '{
    '{2'd0, 2'd0, 4'b0001}, '{2'd0, 2'd1, 4'b0010}, '{2'd0, 2'd2, 4'b0100},
    '{2'd0, 2'd3, 4'b1000}, '{2'd1, 2'd0, 4'b0011}, '{2'd1, 2'd1, 4'b0000},
    '{2'd1, 2'd2, 4'b1100}, '{2'd1, 2'd3, 4'b0000}, '{2'd2, 2'd0, 4'b1111},
    '{2'd2, 2'd2, 4'b0000}, '{2'd3, 2'd0, 4'b0000}
  };

  initial begin
    int n1;
    logic got0;
    reset = 1; lock1 = 0; mem_rdata = 32'hA0A0_0001;
    req_0 = 1; we_0 = 0; addr_0 = 32'h10; size_0 = 2'd2; wdata_0 = 32'h1111_0000;
    req_1 = 1; we_1 = 0; addr_1 = 32'h20; size_1 = 2'd2; wdata_1 = 32'h2222_0000;
    cyc();
    @(negedge clk);
    chk("rst_gnt_0", 32'(gnt_0), 32'h0);
    chk("rst_gnt_1", 32'(gnt_1), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_rvalid_0", 32'(rvalid_0), 32'h0);
    chk("rst_rdata_1", rdata_1, 32'h0);
    cyc();
    reset = 0;

    // Both requesting after reset: strict alternation starting with port 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_gnt_0", 32'(gnt_0), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("alt_gnt_1", 32'(gnt_1), (i % 2 == 1) ? 32'h1 : 32'h0);
      cyc();
    end

    // Half store at 0x102.
    req_1 = 0; req_0 = 1; we_0 = 1; size_0 = 2'd1; addr_0 = 32'h102; wdata_0 = 32'h0000_BEEF;
    @(negedge clk);
    chk("hs_mem_be", 32'(mem_be), 32'hC);
    chk("hs_mem_we", 32'(mem_we), 32'h1);
    chk("hs_mem_addr", mem_addr, 32'h102);
    chk("hs_mem_wdata", mem_wdata, 32'h0000_BEEF);
    cyc();
    req_0 = 0;
    @(negedge clk);
    chk("hs_err_0", 32'(err_0), 32'h0);

    // Misaligned word load on port 1.
    cyc();
    req_1 = 1; we_1 = 0; size_1 = 2'd2; addr_1 = 32'h101;
    @(negedge clk);
    chk("mis_gnt_1", 32'(gnt_1), 32'h1);
    chk("mis_mem_we", 32'(mem_we), 32'h0);
    cyc();
    req_1 = 0;
    @(negedge clk);
    chk("mis_err_1", 32'(err_1), 32'h1);
    chk("mis_rvalid_1", 32'(rvalid_1), 32'h0);
    cyc();
    @(negedge clk);
    chk("mis_err_pulse", 32'(err_1), 32'h0);

    // Aligned word load on port 1.
    cyc();
    req_1 = 1; addr_1 = 32'h40; mem_rdata = 32'h1234_5678;
    cyc();
    req_1 = 0; mem_rdata = 32'hDEAD_0000;
    @(negedge clk);
    chk("ld_rvalid_1", 32'(rvalid_1), 32'h1);
    chk("ld_rdata_1", rdata_1, 32'h1234_5678);
    cyc();
    @(negedge clk);
    chk("ld_rvalid_pulse", 32'(rvalid_1), 32'h0);
    chk("ld_rdata_hold", rdata_1, 32'h1234_5678);

    // Lane code table on port 0 stores.
    cyc();
    for (int i = 0; i < 11; i++) begin
      req_0 = 1; we_0 = 1; size_0 = lane_tbl[i].sz; addr_0 = {30'h80, lane_tbl[i].off};
      wdata_0 = 32'h5A00_0000 + i;
      @(negedge clk);
      chk("lane_be", 32'(mem_be), 32'(lane_tbl[i].be));
      cyc();
    end
    req_0 = 0;
    cyc();

    // Locked burst: port 0 joins after the first grant.
    req_1 = 1; lock1 = 1; we_1 = 0; size_1 = 2'd2; addr_1 = 32'h80;
    n1 = 0; got0 = 0;
    for (int i = 0; i < 20 && !got0; i++) begin
      @(negedge clk);
      if (gnt_1) n1++;
      if (gnt_0) got0 = 1;
      else begin
        cyc();
        if (i == 0) begin req_0 = 1; we_0 = 0; size_0 = 2'd2; addr_0 = 32'h90; end
      end
    end
    chk("lock_p1_grants", 32'(n1), 32'd4);
    chk("lock_then_gnt_0", 32'(got0), 32'h1);
    cyc();
    req_0 = 0; req_1 = 0; lock1 = 0;
    cyc();

    // Reset in the second cycle of a burst.
    req_1 = 1; lock1 = 1; addr_1 = 32'hC0;
    cyc();
    reset = 1;
    @(negedge clk);
    chk("rb_gnt_1", 32'(gnt_1), 32'h0);
    cyc();
    reset = 0; req_1 = 0; lock1 = 0;
    @(negedge clk);
    chk("rb_rvalid_1", 32'(rvalid_1), 32'h0);
    chk("rb_rdata_0", rdata_0, 32'h0);
    chk("rb_rdata_1", rdata_1, 32'h0);
    chk("rb_mem_addr", mem_addr, 32'h0);
    cyc();
    req_0 = 1; req_1 = 1; we_0 = 0; we_1 = 0; addr_0 = 32'h4; addr_1 = 32'h8;
    @(negedge clk);
    chk("rb_first_gnt_0", 32'(gnt_0), 32'h1);
    chk("rb_first_gnt_1", 32'(gnt_1), 32'h0);
    cyc();
    req_0 = 0; req_1 = 0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
